// File: rtl/stem_frame_sequencer_if.sv
// Bundle of every sequencer signal except clock and reset.
// Handshake rule for both w_* and src_*: a word transfers on a rising clk edge
// where valid and ready are both high. ready is a registered sequencer output
// and never depends combinationally on valid. While valid is high and the word
// has not yet transferred, the source keeps data stable.
interface stem_frame_sequencer_if #(
  parameter int data_width = 32,
  parameter int N_W        = 37
);
  logic                      start;
  logic                      w_valid;
  logic [data_width-1:0]     w_data;
  logic                      w_ready;
  logic                      src_valid;
  logic [data_width-1:0]     src_data;
  logic                      src_ready;
  logic [N_W*data_width-1:0] kernel_bus;
  logic                      stem_reset;
  logic                      valid_in;
  logic [data_width-1:0]     pxl_in;
  logic                      valid_out;
  logic [data_width-1:0]     pxl_out;
  logic                      out_valid;
  logic [data_width-1:0]     out_data;
  logic                      out_last;
  logic                      busy;
  logic                      done;
  logic                      err;

  // Sequencer side.
  modport master (
    input  start, w_valid, w_data, src_valid, src_data, valid_out, pxl_out,
    output w_ready, src_ready, kernel_bus, stem_reset, valid_in, pxl_in,
           out_valid, out_data, out_last, busy, done, err
  );

  // Environment side: weight source, pixel source, Stem and consumer.
  modport slave (
    output start, w_valid, w_data, src_valid, src_data, valid_out, pxl_out,
    input  w_ready, src_ready, kernel_bus, stem_reset, valid_in, pxl_in,
           out_valid, out_data, out_last, busy, done, err
  );
endinterface

// File: rtl/stem_frame_sequencer.sv
// Frame sequencer in front of the Stem convolution block: loads the kernel
// weight bank, streams one D*D frame into Stem, collects Stem's outputs and
// closes the frame with a done pulse and an error flag.
module stem_frame_sequencer #(
  parameter int data_width = 32,
  parameter int D          = 299,
  parameter int N_W        = 37,
  parameter int OUT_N      = 22201,
  parameter int TMO        = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  stem_frame_sequencer_if.master io,
  output logic [2:0]            dbg_state_o
);
  localparam int WW = $clog2(N_W);
  localparam int PW = $clog2(D*D);
  localparam int OW = $clog2(OUT_N+1);
  localparam int TW = $clog2(TMO+1);

  localparam logic [WW-1:0] W_LAST = WW'(N_W-1);
  localparam logic [PW-1:0] P_LAST = PW'(D*D-1);
  localparam logic [OW-1:0] O_LAST = OW'(OUT_N);
  localparam logic [TW-1:0] T_LAST = TW'(TMO);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state_q;
  logic [WW-1:0]         w_cnt_q;
  logic [PW-1:0]         p_cnt_q;
  logic [OW-1:0]         o_cnt_q;
  logic [OW-1:0]         o_cnt_d;
  logic [TW-1:0]         tmo_q;
  logic [TW-1:0]         tmo_d;
  logic [data_width-1:0] bank_q [N_W];
  logic                  w_ready_q;
  logic                  src_ready_q;
  logic                  valid_in_q;
  logic [data_width-1:0] pxl_in_q;
  logic                  out_valid_q;
  logic [data_width-1:0] out_data_q;
  logic                  out_last_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic w_fire;
  logic src_fire;
  logic collect;

  assign w_fire   = io.w_valid & w_ready_q;
  assign src_fire = io.src_valid & src_ready_q;
  // Stem may emit before the last pixel goes in, so outputs count in STREAM too.
  assign collect  = io.valid_out & ((state_q == STREAM) | (state_q == DRAIN));
  assign o_cnt_d  = o_cnt_q + 1'b1;
  assign tmo_d    = tmo_q + 1'b1;

  // Sequencing FSM with all outputs, counters and the weight bank registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      w_cnt_q     <= '0;
      p_cnt_q     <= '0;
      o_cnt_q     <= '0;
      tmo_q       <= '0;
      for (int k = 0; k < N_W; k++) bank_q[k] <= '0;
      w_ready_q   <= 1'b0;
      src_ready_q <= 1'b0;
      valid_in_q  <= 1'b0;
      pxl_in_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_in_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;

      // Pixel path into Stem: one register stage, pxl_in holds across gaps.
      if (src_fire) begin
        pxl_in_q   <= io.src_data;
        valid_in_q <= 1'b1;
      end

      // Output path: forward the first OUT_N outputs, flag anything beyond.
      if (collect) begin
        if (o_cnt_q < O_LAST) begin
          out_data_q  <= io.pxl_out;
          out_valid_q <= 1'b1;
          out_last_q  <= (o_cnt_d == O_LAST);
          o_cnt_q     <= o_cnt_d;
        end else begin
          err_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (io.start) begin
            state_q   <= LOAD_W;
            w_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            w_cnt_q   <= '0;
            p_cnt_q   <= '0;
            o_cnt_q   <= '0;
            tmo_q     <= '0;
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            bank_q[w_cnt_q] <= io.w_data;
            if (w_cnt_q == W_LAST) begin
              state_q     <= STREAM;
              w_ready_q   <= 1'b0;
              src_ready_q <= 1'b1;
            end else begin
              w_cnt_q <= w_cnt_q + 1'b1;
            end
          end
        end
        STREAM: begin
          if (src_fire) begin
            if (p_cnt_q == P_LAST) begin
              state_q     <= DRAIN;
              src_ready_q <= 1'b0;
            end else begin
              p_cnt_q <= p_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // A full output count wins over the timeout; any Stem output
          // restarts the idle window.
          if (o_cnt_q == O_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (io.valid_out) begin
            tmo_q <= '0;
          end else if (tmo_d == T_LAST) begin
            tmo_q   <= tmo_d;
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Weight bank onto the flat kernel bus, slot k at [k*data_width +: data_width].
  for (genvar g = 0; g < N_W; g++) begin : g_kernel
    assign io.kernel_bus[g*data_width +: data_width] = bank_q[g];
  end

  // Stem is reset with the sequencer and for the cycle the FSM leaves IDLE.
  assign io.stem_reset = reset | ((state_q == IDLE) & io.start);
  assign io.w_ready    = w_ready_q;
  assign io.src_ready  = src_ready_q;
  assign io.valid_in   = valid_in_q;
  assign io.pxl_in     = pxl_in_q;
  assign io.out_valid  = out_valid_q;
  assign io.out_data   = out_data_q;
  assign io.out_last   = out_last_q;
  assign io.busy       = busy_q;
  assign io.done       = done_q;
  assign io.err        = err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: doc/stem_frame_sequencer.md
Name: stem_frame_sequencer

Overview:
- Controller in front of the Stem convolution block. Per frame it loads the 37 kernel weights into a register bank that drives Stem's kernel inputs.
- It then streams one D×D frame of 32-bit float pixels from a ready/valid source into Stem's pxl_in/valid_in, and collects and counts Stem's output pixels.
- It closes the frame with a done pulse, raising an error flag on timeout or overflow.

Parameters:
- data_width, 32, pixel/weight word width.
- D, 299, frame side length; D*D pixels are streamed per frame.
- N_W, 37, number of kernel weights loaded per frame.
- OUT_N, 22201, expected number of Stem output pixels per frame.
- TMO, 4096, drain timeout in cycles without a Stem output.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, begin a frame; sampled only in IDLE.
- w_valid, in, 1, weight word valid.
- w_data, in, data_width, weight word.
- w_ready, out, 1, sequencer accepts a weight.
- src_valid, in, 1, source pixel valid.
- src_data, in, data_width, source pixel.
- src_ready, out, 1, sequencer accepts a pixel.
- kernel_bus, out, N_W*data_width, weight bank; slot k at [k*data_width +: data_width].
- stem_reset, out, 1, reset to Stem.
- valid_in, out, 1, to Stem.
- pxl_in, out, data_width, to Stem.
- valid_out, in, 1, from Stem.
- pxl_out, in, data_width, from Stem.
- out_valid, out, 1, collected pixel valid.
- out_data, out, data_width, collected pixel.
- out_last, out, 1, marks the OUT_N-th output.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle end-of-frame pulse.
- err, out, 1, error of the last frame.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state:
  - State IDLE; all counters 0.
  - kernel_bus = 0.
  - Outputs w_ready, src_ready, valid_in, out_valid, out_last, done, busy and err are 0.
  - pxl_in = 0, out_data = 0.
  - stem_reset = 1 while reset is high.
- stem_reset: equals reset OR a one-cycle pulse in the cycle the FSM leaves IDLE.
- State machine: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On start = 1, go to LOAD_W, clear err and all counters, and pulse stem_reset.
  - start in any other state is ignored.
- LOAD_W:
  - w_ready = 1.
  - Each cycle with w_valid & w_ready writes w_data into slot w_cnt and increments w_cnt.
  - Slot order: kernel 00..08 of x0, then 00..08 of x1, then 00..08 of x2, then 00 of x4, then 00..08 of x5.
  - Accepting word N_W-1 moves the FSM to STREAM on the next cycle, with w_ready low from that edge.
  - kernel_bus holds its value after the frame; it is overwritten only by the next LOAD_W.
- STREAM:
  - src_ready = 1.
  - Each accepted pixel is registered: pxl_in <= src_data and valid_in <= 1 on the next cycle (latency 1).
  - Cycles with no accepted pixel give valid_in = 0 and hold pxl_in. Gaps are legal for Stem.
  - Accepting pixel D*D-1 moves the FSM to DRAIN, and src_ready drops the same edge.
- Output collection (STREAM and DRAIN):
  - On valid_out = 1, register out_data <= pxl_out and out_valid <= 1 (latency 1), and increment o_cnt.
  - out_last = 1 together with the output where o_cnt reaches OUT_N.
  - Any valid_out after OUT_N outputs is dropped, not forwarded, and sets err.
  - Outputs are counted in STREAM as well as DRAIN (Stem may emit before the frame ends).
- DRAIN:
  - A timeout counter counts up each cycle and is cleared on every valid_out.
  - o_cnt == OUT_N moves the FSM to DONE.
  - Timeout reaching TMO moves the FSM to DONE with err = 1.
  - valid_in = 0.
- DONE: done = 1 for exactly one cycle, then IDLE.
- err holds until the next start.
- Simultaneous events:
  - Reaching the last pixel and a valid_out in the same cycle: both are processed.
  - The OUT_N-th output arriving in STREAM: the FSM still completes STREAM, then DRAIN exits immediately on the next cycle.
- Reset mid-operation: returns to IDLE within one edge; partial kernel_bus contents are cleared; no done pulse is generated.
- Widths:
  - w_cnt is clog2(N_W) bits; pixel counter is clog2(D*D) bits.
  - o_cnt is clog2(OUT_N+1) bits.
  - Timeout counter is clog2(TMO+1) bits.
  - Counters never wrap within a frame.

Test Plan:
- Weight load, D=4, OUT_N=4:
  - Stimulus: start, then 37 words 0x3a83126f/0xba83126f with random w_valid gaps.
  - Required: kernel_bus slot 3 = 0xba83126f and slot 27 = 0x3a83126f; w_ready drops after word 36.
- Streaming with gaps:
  - Stimulus: feed 16 pixels 0..15 with src_valid toggling.
  - Required: valid_in has exactly 16 high cycles, each with pxl_in = the accepted value one cycle after acceptance; src_ready = 0 after pixel 15.
- Normal completion:
  - Stimulus: model Stem valid_out 4 times (2 during STREAM, 2 during DRAIN).
  - Required: 4 out_valid pulses, out_last on the 4th, done for exactly 1 cycle, err = 0, busy low afterwards.
- Timeout, TMO=8:
  - Stimulus: only 3 valid_out pulses.
  - Required: done 8 cycles after the last output, err = 1.
- Overflow:
  - Stimulus: a 5th valid_out before DONE.
  - Required: not forwarded, err = 1.
- Reset and start handling:
  - Stimulus: reset asserted mid-STREAM.
  - Required: next cycle busy = 0, kernel_bus = 0, no done; a start during busy is ignored; a subsequent start runs a clean frame.
